// File: rtl/philo_ring_monitor.sv
// Safety/liveness checker for the dining-philosopher ring: adjacent-eating, starvation, eat-event count.
// Optional snapshot output snap_vec enabled by defining PHILO_MON_SNAPSHOT_EN.
module philo_ring_monitor #(
    parameter int unsigned N            = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned STARVE_LIMIT = 100,
    parameter int unsigned IDX_W        = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*N-1:0]     st_vec,
    input  logic               clear,
    output logic               safety_err,
    output logic [IDX_W-1:0]   safety_idx,
    output logic               starve_flag,
    output logic [IDX_W-1:0]   starve_idx,
    output logic [CNT_W-1:0]   hungry_max,
`ifdef PHILO_MON_SNAPSHOT_EN
    output logic [15:0]        eat_events,
    output logic [2*N-1:0]     snap_vec
`else
    output logic [15:0]        eat_events
`endif
);

    typedef enum logic [1:0] {
        THINKING = 2'd0,
        READING  = 2'd1,
        EATING   = 2'd2,
        HUNGRY   = 2'd3
    } phil_state_e;

    logic [2*N-1:0]   prev_q;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic             err_q, err_d;
    logic [IDX_W-1:0] sidx_q, sidx_d;
    logic             starve_q, starve_d;
    logic [IDX_W-1:0] tidx_q, tidx_d;
    logic [CNT_W-1:0] hmax_q, hmax_d;
    logic [15:0]      eat_q, eat_d;
`ifdef PHILO_MON_SNAPSHOT_EN
    logic [2*N-1:0]   snap_q, snap_d;
`endif

    phil_state_e      st_cur, st_nxt, st_prv;
    logic             viol_any, hit_any;
    logic [IDX_W-1:0] viol_idx, hit_idx;
    logic [15:0]      eat_inc;

    always_comb begin
        viol_any = 1'b0;
        viol_idx = '0;
        hit_any  = 1'b0;
        hit_idx  = '0;
        eat_inc  = '0;
        hmax_d   = '0;
        st_cur   = THINKING;
        st_nxt   = THINKING;
        st_prv   = THINKING;
        for (int unsigned i = 0; i < N; i++) begin
            st_cur = phil_state_e'(st_vec[2*i +: 2]);
            st_nxt = phil_state_e'(st_vec[2*((i + 1 == N) ? 0 : i + 1) +: 2]);
            st_prv = phil_state_e'(prev_q[2*i +: 2]);

            if (st_cur == HUNGRY)
                cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + 1'b1;
            else
                cnt_d[i] = '0;

            // First hit in ascending order wins, giving the lowest index.
            if (st_cur == EATING && st_nxt == EATING && !viol_any) begin
                viol_any = 1'b1;
                viol_idx = IDX_W'(i);
            end
            if (cnt_d[i] >= CNT_W'(STARVE_LIMIT) && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end

            if (st_prv != EATING && st_cur == EATING)
                eat_inc = eat_inc + 16'd1;
            if (cnt_d[i] > hmax_d)
                hmax_d = cnt_d[i];
        end
        eat_d = eat_q + eat_inc;
    end

    // A clear coincident with a new event lets the event win.
    always_comb begin
        err_d    = err_q;
        sidx_d   = sidx_q;
        starve_d = starve_q;
        tidx_d   = tidx_q;
`ifdef PHILO_MON_SNAPSHOT_EN
        snap_d   = snap_q;
`endif
        if (clear) begin
            err_d    = 1'b0;
            sidx_d   = '0;
            starve_d = 1'b0;
            tidx_d   = '0;
`ifdef PHILO_MON_SNAPSHOT_EN
            snap_d   = '0;
`endif
        end
        if ((!err_q || clear) && viol_any) begin
            err_d  = 1'b1;
            sidx_d = viol_idx;
`ifdef PHILO_MON_SNAPSHOT_EN
            snap_d = st_vec;
`endif
        end
        if ((!starve_q || clear) && hit_any) begin
            starve_d = 1'b1;
            tidx_d   = hit_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= '0;
            err_q    <= 1'b0;
            sidx_q   <= '0;
            starve_q <= 1'b0;
            tidx_q   <= '0;
            hmax_q   <= '0;
            eat_q    <= '0;
`ifdef PHILO_MON_SNAPSHOT_EN
            snap_q   <= '0;
`endif
            for (int unsigned i = 0; i < N; i++)
                cnt_q[i] <= '0;
        end else begin
            prev_q   <= st_vec;
            err_q    <= err_d;
            sidx_q   <= sidx_d;
            starve_q <= starve_d;
            tidx_q   <= tidx_d;
            hmax_q   <= hmax_d;
            eat_q    <= eat_d;
`ifdef PHILO_MON_SNAPSHOT_EN
            snap_q   <= snap_d;
`endif
            for (int unsigned i = 0; i < N; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    assign safety_err  = err_q;
    assign safety_idx  = sidx_q;
    assign starve_flag = starve_q;
    assign starve_idx  = tidx_q;
    assign hungry_max  = hmax_q;
    assign eat_events  = eat_q;
`ifdef PHILO_MON_SNAPSHOT_EN
    assign snap_vec    = snap_q;
`endif

endmodule

// File: tb/tb_philo_ring_monitor.sv
// Self-checking bench for philo_ring_monitor: vector table, directed corner sequences, randomized run vs model.
module tb_philo_ring_monitor;
    localparam int N     = 8;
    localparam int CNT_W = 8;
    localparam int LIM   = 100;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic [2*N-1:0]   st_vec = '0;
    logic             safety_err, starve_flag;
    logic [IDX_W-1:0] safety_idx, starve_idx;
    logic [CNT_W-1:0] hungry_max;
    logic [15:0]      eat_events;
`ifdef PHILO_MON_SNAPSHOT_EN
    logic [2*N-1:0]   snap_vec;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    philo_ring_monitor #(.N(N), .CNT_W(CNT_W), .STARVE_LIMIT(LIM), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .st_vec(st_vec), .clear(clear),
        .safety_err(safety_err), .safety_idx(safety_idx),
        .starve_flag(starve_flag), .starve_idx(starve_idx),
        .hungry_max(hungry_max),
`ifdef PHILO_MON_SNAPSHOT_EN
        .eat_events(eat_events),
        .snap_vec(snap_vec)
`else
        .eat_events(eat_events)
`endif
    );

    // Reference model: plain integer bookkeeping of the ring
    int          m_cnt [N];
    int          m_prev [N];
    bit          m_err, m_starve;
    int          m_sidx, m_tidx, m_hmax, m_eat;
    logic [15:0] m_snap;

    function automatic int ph(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> (2 * i);
        return int'(t[1:0]);
    endfunction

    task automatic model_step(input logic [15:0] v, input bit clr, input bit rst);
        int vi, hi, ev;
        if (rst) begin
            foreach (m_cnt[i]) begin m_cnt[i] = 0; m_prev[i] = 0; end
            m_err = 0; m_starve = 0; m_sidx = 0; m_tidx = 0;
            m_hmax = 0; m_eat = 0; m_snap = '0;
            return;
        end
        vi = -1; hi = -1; ev = 0; m_hmax = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = (ph(v, i) == 3) ? ((m_cnt[i] < 255) ? m_cnt[i] + 1 : 255) : 0;
            if (m_cnt[i] > m_hmax) m_hmax = m_cnt[i];
            if (vi < 0 && ph(v, i) == 2 && ph(v, (i + 1) % N) == 2) vi = i;
            if (hi < 0 && m_cnt[i] >= LIM) hi = i;
            if (m_prev[i] != 2 && ph(v, i) == 2) ev++;
            m_prev[i] = ph(v, i);
        end
        m_eat = (m_eat + ev) % 65536;
        if (clr) begin
            m_err = 0; m_sidx = 0; m_starve = 0; m_tidx = 0; m_snap = '0;
        end
        if (!m_err && vi >= 0) begin m_err = 1; m_sidx = vi; m_snap = v; end
        if (!m_starve && hi >= 0) begin m_starve = 1; m_tidx = hi; end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [15:0] v, input bit clr = 0, input bit rst = 0);
        @(negedge clk);
        st_vec = v; clear = clr; reset = rst;
        @(posedge clk);
        model_step(v, clr, rst);
        #1;
        check("m_safety_err", 32'(safety_err), 32'(m_err));
        check("m_safety_idx", 32'(safety_idx), 32'(m_sidx));
        check("m_starve_flag", 32'(starve_flag), 32'(m_starve));
        check("m_starve_idx", 32'(starve_idx), 32'(m_tidx));
        check("m_hungry_max", 32'(hungry_max), 32'(m_hmax));
        check("m_eat_events", 32'(eat_events), 32'(m_eat));
`ifdef PHILO_MON_SNAPSHOT_EN
        check("m_snap_vec", 32'(snap_vec), 32'(m_snap));
`endif
    endtask

    typedef struct {
        logic [15:0] st;
        bit          clr;
        bit          rst;
        bit          e_err;
        int          e_idx;
        int          e_eat;
        logic [15:0] e_snap;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] v;
        int          rem, k, hog;
        bit          clr, rst;

        tbl[0] = '{16'h0000, 1'b0, 1'b1, 1'b0, 0, 0, 16'h0000};
        tbl[1] = '{16'h00A0, 1'b0, 1'b0, 1'b1, 2, 2, 16'h00A0};
        tbl[2] = '{16'h2800, 1'b0, 1'b0, 1'b1, 2, 4, 16'h00A0};
        tbl[3] = '{16'h0000, 1'b1, 1'b0, 1'b0, 0, 4, 16'h0000};
        tbl[4] = '{16'h8002, 1'b0, 1'b0, 1'b1, 7, 6, 16'h8002};
        tbl[5] = '{16'h000A, 1'b1, 1'b0, 1'b1, 0, 7, 16'h000A};
        tbl[6] = '{16'h0000, 1'b0, 1'b0, 1'b1, 0, 7, 16'h000A};

        // Reset and idle thinking
        step(16'h0000, 0, 1);
        check("rst_err", 32'(safety_err), 0);
        check("rst_starve", 32'(starve_flag), 0);
        check("rst_hmax", 32'(hungry_max), 0);
        check("rst_eat", 32'(eat_events), 0);
        for (int i = 0; i < 10; i++) step(16'h0000);
        check("idle_err", 32'(safety_err), 0);
        check("idle_idx", 32'(safety_idx), 0);
        check("idle_starve", 32'(starve_flag), 0);
        check("idle_eat", 32'(eat_events), 0);

        // Safety vectors
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].st, tbl[i].clr, tbl[i].rst);
            check($sformatf("tbl%0d_err", i), 32'(safety_err), 32'(tbl[i].e_err));
            check($sformatf("tbl%0d_idx", i), 32'(safety_idx), 32'(tbl[i].e_idx));
            check($sformatf("tbl%0d_eat", i), 32'(eat_events), 32'(tbl[i].e_eat));
            check($sformatf("tbl%0d_starve", i), 32'(starve_flag), 0);
`ifdef PHILO_MON_SNAPSHOT_EN
            check($sformatf("tbl%0d_snap", i), 32'(snap_vec), 32'(tbl[i].e_snap));
`endif
        end

        // Starvation of ph4
        step(16'h0000, 0, 1);
        for (int i = 0; i < 99; i++) step(16'h0300);
        check("h99_starve", 32'(starve_flag), 0);
        check("h99_hmax", 32'(hungry_max), 99);
        step(16'h0300);
        check("h100_starve", 32'(starve_flag), 1);
        check("h100_idx", 32'(starve_idx), 4);
        check("h100_hmax", 32'(hungry_max), 100);
        for (int i = 0; i < 200; i++) step(16'h0300);
        check("h300_hmax", 32'(hungry_max), 255);
        step(16'h0300, 1, 0);
        check("hclr_starve", 32'(starve_flag), 1);
        check("hclr_idx", 32'(starve_idx), 4);
        step(16'h0000);
        check("hthink_hmax", 32'(hungry_max), 0);
        check("hthink_starve", 32'(starve_flag), 1);
        step(16'h0000, 1, 0);
        check("hthink_clr", 32'(starve_flag), 0);

        // Reset in the middle of a hungry run
        for (int i = 0; i < 50; i++) step(16'h0300);
        step(16'h0300, 1, 1);
        check("mrst_hmax", 32'(hungry_max), 0);
        check("mrst_eat", 32'(eat_events), 0);
        check("mrst_err", 32'(safety_err), 0);
        step(16'h0300);
        check("mrst_restart", 32'(hungry_max), 1);

        // Eat events and 16-bit wrap
        step(16'h0000, 0, 1);
        step(16'h0000);
        step(16'h0888);
        check("eat_plus3", 32'(eat_events), 3);
        for (int i = 0; i < 5; i++) step(16'h0888);
        check("eat_hold", 32'(eat_events), 3);
        step(16'h0000);
        rem = (65534 - m_eat) & 16'hFFFF;
        while (rem > 0) begin
            k = (rem < N) ? rem : N;
            v = '0;
            for (int j = 0; j < k; j++) v[2*j +: 2] = 2'd2;
            step(v);
            step(16'h0000);
            rem = (65534 - m_eat) & 16'hFFFF;
        end
        check("eat_preload", 32'(eat_events), 65534);
        step(16'h0888);
        check("eat_wrap", 32'(eat_events), 1);

        // Randomized run with a rotating, mostly-hungry philosopher
        step(16'h0000, 0, 1);
        for (int r = 0; r < 3000; r++) begin
            hog = (r / 500) % N;
            v = 16'($urandom);
            if ($urandom_range(0, 199) != 0) v[2*hog +: 2] = 2'd3;
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step(v, clr, rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
